// File: rtl/forward_hazard_unit.sv
// Decode-stage RAW hazard resolver: picks the youngest forwarding source per operand,
// raises stall on unresolvable hazards, and tracks stall cause, stall statistics and a watchdog.
module forward_hazard_unit #(
  parameter int NSRC          = 2,
  parameter int NSTAGE        = 3,
  parameter int AW            = 5,
  parameter int STALL_TIMEOUT = 64,
  localparam int SELW         = $clog2(NSTAGE + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 fwd_en,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_ren,
  input  logic [NSTAGE*AW-1:0] stg_wsel,
  input  logic [NSTAGE-1:0]    stg_wen,
  input  logic [NSTAGE-1:0]    stg_isload,
  input  logic                 dhit,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic [1:0]           stall_cause,
  output logic [31:0]          stall_cycles,
  output logic                 stall_err
);

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOADUSE = 2'd1,
    CAUSE_MEMWAIT = 2'd2,
    CAUSE_RAWOFF  = 2'd3
  } cause_e;

  localparam int RUNW = $clog2(STALL_TIMEOUT + 1);

  logic            mem_wait;
  logic [SELW-1:0] young_sel [NSRC];
  logic [NSRC*SELW-1:0] sel_raw;
  logic            hz_loaduse, hz_memwait, hz_rawoff;

  cause_e      stall_cause_d, stall_cause_q;
  logic [31:0] stall_cycles_d, stall_cycles_q;
  logic [RUNW-1:0] run_d, run_q;
  logic        stall_err_d, stall_err_q;

  // A load in MEM only blocks forwarding until the dcache returns its data.
  generate
    if (NSTAGE > 1) begin : g_mem
      assign mem_wait = stg_isload[1] & ~dhit;
    end else begin : g_no_mem
      assign mem_wait = 1'b0;
    end
  endgenerate

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    hz_loaduse = 1'b0;
    hz_memwait = 1'b0;
    hz_rawoff  = 1'b0;
    sel_raw    = '0;
    for (int i = 0; i < NSRC; i++) begin
      young_sel[i] = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (id_ren[i] && stg_wen[s] && (id_rs[i*AW +: AW] != '0) &&
            (id_rs[i*AW +: AW] == stg_wsel[s*AW +: AW])) begin
          young_sel[i] = SELW'(s + 1);
        end
      end
      if (young_sel[i] != '0) begin
        if (!fwd_en)                                        hz_rawoff  = 1'b1;
        else if (young_sel[i] == SELW'(1) && stg_isload[0]) hz_loaduse = 1'b1;
        else if (young_sel[i] == SELW'(2) && mem_wait)      hz_memwait = 1'b1;
        else sel_raw[i*SELW +: SELW] = young_sel[i];
      end
    end
  end

  assign stall   = hz_loaduse | hz_memwait | hz_rawoff;
  assign fwd_sel = stall ? '0 : sel_raw;

  always_comb begin
    stall_cause_d = CAUSE_NONE;
    if (hz_loaduse)      stall_cause_d = CAUSE_LOADUSE;
    else if (hz_memwait) stall_cause_d = CAUSE_MEMWAIT;
    else if (hz_rawoff)  stall_cause_d = CAUSE_RAWOFF;

    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;

    run_d = '0;
    if (stall) run_d = (run_q == RUNW'(STALL_TIMEOUT)) ? run_q : run_q + 1'b1;

    stall_err_d = stall_err_q | (run_d == RUNW'(STALL_TIMEOUT));
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cause_q  <= CAUSE_NONE;
      stall_cycles_q <= '0;
      run_q          <= '0;
      stall_err_q    <= 1'b0;
    end else begin
      stall_cause_q  <= stall_cause_d;
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      stall_err_q    <= stall_err_d;
    end
  end

  assign stall_cause  = stall_cause_q;
  assign stall_cycles = stall_cycles_q;
  assign stall_err    = stall_err_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding selection, hazard causes,
// counters, watchdog and asynchronous reset, with hand-computed expectations.
module tb_forward_hazard_unit;

  localparam int NSRC = 2, NSTAGE = 3, AW = 5, TMO = 64, SELW = 2;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 fwd_en;
  logic [NSRC*AW-1:0]   id_rs;
  logic [NSRC-1:0]      id_ren;
  logic [NSTAGE*AW-1:0] stg_wsel;
  logic [NSTAGE-1:0]    stg_wen;
  logic [NSTAGE-1:0]    stg_isload;
  logic                 dhit;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic [1:0]           stall_cause;
  logic [31:0]          stall_cycles;
  logic                 stall_err;

  int errors = 0;
  int checks = 0;

  forward_hazard_unit #(.NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW), .STALL_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .fwd_en(fwd_en), .id_rs(id_rs), .id_ren(id_ren),
    .stg_wsel(stg_wsel), .stg_wen(stg_wen), .stg_isload(stg_isload), .dhit(dhit),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cause(stall_cause),
    .stall_cycles(stall_cycles), .stall_err(stall_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench timeout");
  end

  task automatic clear_inputs();
    fwd_en = 1'b1; id_rs = '0; id_ren = '0; stg_wsel = '0;
    stg_wen = '0; stg_isload = '0; dhit = 1'b0;
  endtask

  task automatic set_rs(input int i, input logic [AW-1:0] r);
    id_rs[i*AW +: AW] = r;
    id_ren[i] = 1'b1;
  endtask

  task automatic set_stage(input int s, input logic [AW-1:0] w, input logic ld);
    stg_wsel[s*AW +: AW] = w;
    stg_wen[s] = 1'b1;
    stg_isload[s] = ld;
  endtask

  task automatic test_reset();
    clear_inputs();
    #3;
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d exp 0", stall_cause); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d exp 0", stall_cycles); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", stall_err); end
    set_rs(0, 5'd5); set_stage(0, 5'd5, 1'b0);
    #1;
    checks++; if (fwd_sel !== 4'h1) begin errors++; $display("FAIL reset_comb_sel: got %0h exp 1", fwd_sel); end
    @(negedge CLK); clear_inputs(); RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL post_reset_cycles: got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_forward();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd5); id_rs[AW +: AW] = 5'd5;
    set_stage(0, 5'd5, 1'b0); set_stage(1, 5'd5, 1'b1);
    #1;
    checks++; if (fwd_sel !== 4'h1) begin errors++; $display("FAIL fwd_youngest_sel: got %0h exp 1", fwd_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_youngest_stall: got %0b exp 0", stall); end
    set_rs(1, 5'd9); set_stage(2, 5'd9, 1'b0);
    #1;
    checks++; if (fwd_sel !== 4'hD) begin errors++; $display("FAIL fwd_two_ops_sel: got %0h exp d", fwd_sel); end
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL fwd_cause: got %0d exp 0", stall_cause); end
  endtask

  task automatic test_loaduse();
    @(negedge CLK); clear_inputs();
    set_rs(1, 5'd7); set_stage(0, 5'd7, 1'b1);
    set_rs(0, 5'd9); set_stage(2, 5'd9, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %0b exp 1", stall); end
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL loaduse_sel_forced: got %0h exp 0", fwd_sel); end
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL loaduse_cause_lag: got %0d exp 0", stall_cause); end
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd1) begin errors++; $display("FAIL loaduse_cause: got %0d exp 1", stall_cause); end
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL loaduse_cycles: got %0d exp 1", stall_cycles); end
  endtask

  task automatic test_memwait();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd7); set_stage(1, 5'd7, 1'b1); dhit = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL memwait_stall: got %0b exp 1", stall); end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (stall_cause !== 2'd2) begin errors++; $display("FAIL memwait_cause: got %0d exp 2", stall_cause); end
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL memwait_cycles: got %0d exp 4", stall_cycles); end
    @(negedge CLK); dhit = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dhit_stall: got %0b exp 0", stall); end
    checks++; if (fwd_sel !== 4'h2) begin errors++; $display("FAIL dhit_sel: got %0h exp 2", fwd_sel); end
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL dhit_cause: got %0d exp 0", stall_cause); end
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL dhit_cycles: got %0d exp 4", stall_cycles); end
  endtask

  task automatic test_priority();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd7); set_stage(1, 5'd7, 1'b1);
    set_rs(1, 5'd8); set_stage(0, 5'd8, 1'b1);
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd1) begin errors++; $display("FAIL prio_cause: got %0d exp 1", stall_cause); end
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL prio_cycles: got %0d exp 5", stall_cycles); end
  endtask

  task automatic test_zero_and_rawoff();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd0); set_stage(0, 5'd0, 1'b0);
    #1;
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL r0_sel: got %0h exp 0", fwd_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %0b exp 0", stall); end
    clear_inputs(); fwd_en = 1'b0;
    set_rs(0, 5'd3); set_stage(2, 5'd3, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rawoff_stall: got %0b exp 1", stall); end
    checks++; if (fwd_sel !== 4'h0) begin errors++; $display("FAIL rawoff_sel: got %0h exp 0", fwd_sel); end
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd3) begin errors++; $display("FAIL rawoff_cause: got %0d exp 3", stall_cause); end
    checks++; if (stall_cycles !== 32'd6) begin errors++; $display("FAIL rawoff_cycles: got %0d exp 6", stall_cycles); end
    @(negedge CLK); clear_inputs();
    @(posedge CLK); #1;
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL clear_cause: got %0d exp 0", stall_cause); end
  endtask

  task automatic test_watchdog();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd7); set_stage(0, 5'd7, 1'b1);
    repeat (TMO - 1) @(posedge CLK);
    #1;
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL wd_early: got %0b exp 0", stall_err); end
    checks++; if (stall_cycles !== 32'd69) begin errors++; $display("FAIL wd_cycles63: got %0d exp 69", stall_cycles); end
    @(posedge CLK); #1;
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL wd_set: got %0b exp 1", stall_err); end
    checks++; if (stall_cycles !== 32'd70) begin errors++; $display("FAIL wd_cycles64: got %0d exp 70", stall_cycles); end
    @(negedge CLK); clear_inputs();
    @(posedge CLK); #1;
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b exp 1", stall_err); end
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL wd_drop_cause: got %0d exp 0", stall_cause); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge CLK); clear_inputs();
    set_rs(0, 5'd7); set_stage(0, 5'd7, 1'b1);
    @(posedge CLK); #1;
    checks++; if (stall_cycles !== 32'd71) begin errors++; $display("FAIL pre_rst_cycles: got %0d exp 71", stall_cycles); end
    #2 RST = 1'b1;
    #1;
    checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL async_rst_cause: got %0d exp 0", stall_cause); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL async_rst_cycles: got %0d exp 0", stall_cycles); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %0b exp 0", stall_err); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_comb_stall: got %0b exp 1", stall); end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL restart_cycles: got %0d exp 1", stall_cycles); end
    checks++; if (stall_cause !== 2'd1) begin errors++; $display("FAIL restart_cause: got %0d exp 1", stall_cause); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_loaduse();
    test_memwait();
    test_priority();
    test_zero_and_rawoff();
    test_watchdog();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
